// File: rtl/seq_divider.sv
// Sequential unsigned divider by repeated subtraction with a start/done handshake.
// Optional SEQ_DIV_CYCLE_CNT_EN adds a 'cycles' output counting SUB-state edges.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
`ifdef SEQ_DIV_CYCLE_CNT_EN
  ,
  output logic [WIDTH-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvs_q;
  logic             accept;
  logic             fits;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign fits   = (remainder >= dvs_q);
  assign busy   = (state == SUB);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (divisor == '0) ? DONE : SUB;
      SUB:        if (!fits) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvs_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (accept) begin
      dvs_q     <= divisor;
      remainder <= dividend;
      // divide-by-zero reports all-ones quotient and skips SUB entirely
      quotient  <= (divisor == '0) ? '1 : '0;
      dbz       <= (divisor == '0);
    end else if (busy && fits) begin
      remainder <= remainder - dvs_q;
      quotient  <= quotient + 1'b1;
    end
  end

`ifdef SEQ_DIV_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         cycles <= '0;
    else if (accept) cycles <= '0;
    else if (busy)   cycles <= cycles + 1'b1;
  end
`endif

endmodule
